// File: rtl/rc4_decrypt_message_if.sv
// Bus bundle for the RC4 keystream/decrypt stage: start/done handshake,
// S-memory port, encrypted-message ROM port and decrypted-message RAM port.
interface rc4_decrypt_message_if #(
  parameter int MSG_AW = 5
);
  logic              start;
  logic              done;
  logic              msg_valid;
  logic [7:0]        s_addr;
  logic [7:0]        s_rdata;
  logic [7:0]        s_wdata;
  logic              s_we;
  logic [MSG_AW-1:0] rom_addr;
  logic [7:0]        rom_rdata;
  logic [MSG_AW-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;

  // Decrypt engine side: drives memory addresses/writes and status.
  modport master (
    input  start, s_rdata, rom_rdata,
    output done, msg_valid, s_addr, s_wdata, s_we,
           rom_addr, ram_addr, ram_wdata, ram_we
  );

  // Memory/controller side.
  modport slave (
    output start, s_rdata, rom_rdata,
    input  done, msg_valid, s_addr, s_wdata, s_we,
           rom_addr, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/rc4_decrypt_message.sv
// RC4 PRGA stage: walks the shuffled S array, swaps entries, XORs the
// keystream with the encrypted ROM and writes plaintext to the RAM.
// Flags whether every plaintext byte is a lowercase letter or a space.
//
// state  | meaning
// IDLE   | waiting for start
// RD_I   | present S[i] address
// LD_I   | capture si, advance j
// RD_J   | present S[j] address
// LD_J   | capture sj
// WR_I   | S[i] <= sj
// WR_J   | S[j] <= si
// RD_F   | present S[si+sj] and ROM[k] addresses
// LD_F   | capture keystream byte and encrypted byte
// WR_OUT | write plaintext, check character class
// DONE   | run finished, wait for start to drop
module rc4_decrypt_message #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  rc4_decrypt_message_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J, RD_F, LD_F, WR_OUT, DONE
  } state_t;

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  state_t            state_q, state_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [7:0]        si_q, si_d;
  logic [7:0]        sj_q, sj_d;
  logic [7:0]        f_q, f_d;
  logic [7:0]        enc_q, enc_d;
  logic              msg_valid_q, msg_valid_d;

  logic [7:0] plain;
  logic       char_ok;

  assign plain   = f_q ^ enc_q;
  assign char_ok = ((plain >= 8'h61) && (plain <= 8'h7a)) || (plain == 8'h20);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      f_q         <= '0;
      enc_q       <= '0;
      msg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      f_q         <= f_d;
      enc_q       <= enc_d;
      msg_valid_q <= msg_valid_d;
    end
  end

  // Next-state and register updates, one byte per nine-state pass.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    si_d        = si_q;
    sj_d        = sj_q;
    f_d         = f_q;
    enc_d       = enc_q;
    msg_valid_d = msg_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RD_I;
          i_d         = 8'd1;
          j_d         = 8'd0;
          k_d         = '0;
          msg_valid_d = 1'b1;
        end
      end
      RD_I: state_d = LD_I;
      LD_I: begin
        si_d    = bus.s_rdata;
        j_d     = j_q + bus.s_rdata;
        state_d = RD_J;
      end
      RD_J: state_d = LD_J;
      LD_J: begin
        sj_d    = bus.s_rdata;
        state_d = WR_I;
      end
      WR_I: state_d = WR_J;
      WR_J: state_d = RD_F;
      RD_F: state_d = LD_F;
      LD_F: begin
        f_d     = bus.s_rdata;
        enc_d   = bus.rom_rdata;
        state_d = WR_OUT;
      end
      WR_OUT: begin
        // The offending byte is still written; the run just stops here.
        if (!char_ok) begin
          msg_valid_d = 1'b0;
          state_d     = DONE;
        end else if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = k_q + 1'b1;
          state_d = RD_I;
        end
      end
      DONE: begin
        if (!bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode; everything idles at zero outside its own state.
  always_comb begin
    bus.s_addr    = 8'h00;
    bus.s_wdata   = 8'h00;
    bus.s_we      = 1'b0;
    bus.rom_addr  = '0;
    bus.ram_addr  = '0;
    bus.ram_wdata = 8'h00;
    bus.ram_we    = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      RD_I: bus.s_addr = i_q;
      RD_J: bus.s_addr = j_q;
      WR_I: begin
        bus.s_addr  = i_q;
        bus.s_wdata = sj_q;
        bus.s_we    = 1'b1;
      end
      // When i == j this rewrites the same cell with si, leaving S intact.
      WR_J: begin
        bus.s_addr  = j_q;
        bus.s_wdata = si_q;
        bus.s_we    = 1'b1;
      end
      RD_F: begin
        bus.s_addr   = si_q + sj_q;
        bus.rom_addr = k_q;
      end
      WR_OUT: begin
        bus.ram_addr  = k_q;
        bus.ram_wdata = plain;
        bus.ram_we    = 1'b1;
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.msg_valid = msg_valid_q;

endmodule

// File: tb/tb_rc4_decrypt_message.sv
// Self-checking bench for rc4_decrypt_message: cycle-exact vector table for
// the identity-S scenarios plus randomized S/plaintext runs checked against a
// plain RC4 PRGA reference model.
module tb_rc4_decrypt_message;
  localparam int MSG_LEN = 32;
  localparam int MSG_AW  = 5;
  localparam int MAXC    = 400;
  localparam int BUDGET  = 330;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rc4_decrypt_message_if #(.MSG_AW(MSG_AW)) bus ();

  rc4_decrypt_message #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Memories with one-cycle read latency; load_s copies init_s into S.
  logic [7:0] s_mem  [256];
  logic [7:0] init_s [256];
  logic [7:0] rom    [MSG_LEN];
  logic       load_s = 1'b0;

  always @(posedge clk) begin
    if (load_s) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= init_s[x];
    end else if (bus.s_we) begin
      s_mem[bus.s_addr] <= bus.s_wdata;
    end
    bus.s_rdata   <= s_mem[bus.s_addr];
    bus.rom_rdata <= rom[bus.rom_addr];
  end

  int total = 0;
  int bad   = 0;

  // Per-cycle capture of DUT outputs (index = cycle number after start edge).
  bit         c_swe  [MAXC];
  logic [7:0] c_sa   [MAXC];
  logic [7:0] c_sd   [MAXC];
  bit         c_rwe  [MAXC];
  logic [4:0] c_ra   [MAXC];
  logic [7:0] c_rd   [MAXC];
  bit         c_done [MAXC];
  bit         c_mv   [MAXC];

  // Reference model results.
  logic [7:0] m_s [256];
  logic [7:0] ks  [MSG_LEN];
  int         exp_ram[$];
  int         exp_sw[$];
  bit         exp_mv;
  int         exp_n;

  typedef struct {
    int         scen;
    int         cyc;
    bit         s_we;
    logic [7:0] s_addr;
    logic [7:0] s_wdata;
    bit         ram_we;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata;
    bit         done;
    bit         mv;
  } vec_t;

  vec_t tbl [13];

  function automatic bit is_ok(input logic [7:0] p);
    return ((p >= 8'h61) && (p <= 8'h7a)) || (p == 8'h20);
  endfunction

  // Textbook RC4 PRGA over init_s/rom; full=1 ignores the abort rule.
  function automatic void model(input bit full);
    logic [7:0] i, j, a, b, t, p;
    for (int x = 0; x < 256; x++) m_s[x] = init_s[x];
    i = 8'd0;
    j = 8'd0;
    exp_ram.delete();
    exp_sw.delete();
    exp_mv = 1'b1;
    exp_n  = 0;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      a = m_s[i];
      b = m_s[j];
      exp_sw.push_back((int'(i) << 8) | int'(b));
      exp_sw.push_back((int'(j) << 8) | int'(a));
      m_s[i] = b;
      m_s[j] = a;
      t = a + b;
      ks[k] = m_s[t];
      p = ks[k] ^ rom[k];
      exp_ram.push_back((k << 8) | int'(p));
      exp_n = k + 1;
      if (!full && !is_ok(p)) begin
        exp_mv = 1'b0;
        break;
      end
    end
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic rec(input int c);
    c_swe[c]  = bus.s_we;
    c_sa[c]   = bus.s_addr;
    c_sd[c]   = bus.s_wdata;
    c_rwe[c]  = bus.ram_we;
    c_ra[c]   = bus.ram_addr;
    c_rd[c]   = bus.ram_wdata;
    c_done[c] = bus.done;
    c_mv[c]   = bus.msg_valid;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic load();
    load_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_s = 1'b0;
  endtask

  task automatic set_identity();
    for (int x = 0; x < 256; x++) init_s[x] = 8'(x);
  endtask

  // Raise start at a negedge (sampled at edge 0) and capture until done.
  task automatic run(input bit hold, output int dcyc);
    for (int c = 0; c < MAXC; c++) rec_clear(c);
    dcyc = 0;
    bus.start = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      rec(c);
      if (bus.done) begin
        dcyc = c;
        break;
      end
    end
    if (dcyc == 0) begin
      total++;
      bad++;
      $display("FAIL run_timeout got=no_done expected=done_within_%0d", BUDGET);
    end
  endtask

  task automatic rec_clear(input int c);
    c_swe[c] = 0; c_sa[c] = 0; c_sd[c] = 0; c_rwe[c] = 0;
    c_ra[c] = 0;  c_rd[c] = 0; c_done[c] = 0; c_mv[c] = 0;
  endtask

  task automatic check_table(input int scen);
    logic [32:0] got, exp;
    int c;
    foreach (tbl[n]) begin
      if (tbl[n].scen == scen) begin
        c = tbl[n].cyc;
        got = {c_swe[c], c_sa[c], c_sd[c], c_rwe[c], c_ra[c], c_rd[c],
               c_done[c], c_done[c] ? c_mv[c] : 1'b0};
        exp = {tbl[n].s_we, tbl[n].s_addr, tbl[n].s_wdata, tbl[n].ram_we,
               tbl[n].ram_addr, tbl[n].ram_wdata, tbl[n].done,
               tbl[n].done ? tbl[n].mv : 1'b0};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL vec_s%0d_cyc%0d got=%h expected=%h", scen, c, got, exp);
        end
      end
    end
  endtask

  // Compare a captured run against the model results currently held.
  task automatic check_run(input string tag, input int dcyc);
    int got_ram[$];
    int got_sw[$];
    bit ok;
    chk({tag, "_done_cycle"}, dcyc, 9 * exp_n + 1);
    for (int c = 1; c <= dcyc; c++) begin
      if (c_rwe[c]) got_ram.push_back((int'(c_ra[c]) << 8) | int'(c_rd[c]));
      if (c_swe[c]) got_sw.push_back((int'(c_sa[c]) << 8) | int'(c_sd[c]));
    end
    ok = (got_ram.size() == exp_ram.size());
    if (ok) foreach (got_ram[n]) if (got_ram[n] != exp_ram[n]) ok = 0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_ram_writes got_count=%0d expected_count=%0d", tag,
               got_ram.size(), exp_ram.size());
    end
    ok = (got_sw.size() == exp_sw.size());
    if (ok) foreach (got_sw[n]) if (got_sw[n] != exp_sw[n]) ok = 0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_s_writes got_count=%0d expected_count=%0d", tag,
               got_sw.size(), exp_sw.size());
    end
    chk({tag, "_msg_valid"}, int'(c_mv[dcyc]), int'(exp_mv));
    ok = 1;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) ok = 0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_final_s got=differs expected=model", tag);
    end
  endtask

  // Scenario 0: identity S, plaintext all 'a'.
  task automatic setup_all_a();
    set_identity();
    for (int k = 0; k < MSG_LEN; k++) rom[k] = 8'h00;
    model(1'b1);
    for (int k = 0; k < MSG_LEN; k++) rom[k] = 8'h61 ^ ks[k];
    model(1'b0);
  endtask

  logic [7:0] bad_chars [6];

  initial begin
    int d;
    logic [7:0] tmp, p;
    int y;

    tbl[0]  = '{0,   1, 1'b0, 8'h01, 8'h00, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0};
    tbl[1]  = '{0,   5, 1'b1, 8'h01, 8'h01, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0};
    tbl[2]  = '{0,   6, 1'b1, 8'h01, 8'h01, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0};
    tbl[3]  = '{0,   7, 1'b0, 8'h02, 8'h00, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0};
    tbl[4]  = '{0,   8, 1'b0, 8'h00, 8'h00, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0};
    tbl[5]  = '{0,   9, 1'b0, 8'h00, 8'h00, 1'b1, 5'd0,  8'h61, 1'b0, 1'b0};
    tbl[6]  = '{0,  14, 1'b1, 8'h02, 8'h03, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0};
    tbl[7]  = '{0,  15, 1'b1, 8'h03, 8'h02, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0};
    tbl[8]  = '{0,  18, 1'b0, 8'h00, 8'h00, 1'b1, 5'd1,  8'h61, 1'b0, 1'b0};
    tbl[9]  = '{0, 288, 1'b0, 8'h00, 8'h00, 1'b1, 5'd31, 8'h61, 1'b0, 1'b0};
    tbl[10] = '{0, 289, 1'b0, 8'h00, 8'h00, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1};
    tbl[11] = '{1,  18, 1'b0, 8'h00, 8'h00, 1'b1, 5'd1,  8'h05, 1'b0, 1'b0};
    tbl[12] = '{1,  19, 1'b0, 8'h00, 8'h00, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0};

    bad_chars[0] = 8'h60; bad_chars[1] = 8'h7b; bad_chars[2] = 8'h1f;
    bad_chars[3] = 8'h21; bad_chars[4] = 8'h41; bad_chars[5] = 8'h00;

    bus.start = 1'b0;
    rst = 1'b1;
    set_identity();
    for (int k = 0; k < MSG_LEN; k++) rom[k] = 8'h00;
    @(negedge clk);
    load();
    idle(2);
    // Reset state
    chk("rst_s_we", int'(bus.s_we), 0);
    chk("rst_ram_we", int'(bus.ram_we), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_msg_valid", int'(bus.msg_valid), 0);
    chk("rst_addr_data", int'({bus.s_addr, bus.s_wdata, bus.rom_addr,
                              bus.ram_addr, bus.ram_wdata}), 0);
    rst = 1'b0;
    idle(1);

    // Full valid message over identity S
    setup_all_a();
    load();
    idle(1);
    run(1'b0, d);
    check_table(0);
    check_run("full", d);

    // Early abort at byte 1
    idle(2);
    set_identity();
    rom[0] = 8'h63;
    rom[1] = 8'h00;
    load();
    model(1'b0);
    run(1'b0, d);
    check_table(1);
    check_run("abort", d);
    y = 0;
    for (int c = 1; c <= d; c++) if (c_rwe[c] && c_ra[c] == 5'd2) y++;
    chk("abort_no_addr2", y, 0);

    // Reset asserted mid-run, then a clean rerun
    idle(2);
    setup_all_a();
    load();
    idle(1);
    bus.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 12) rst = 1'b1;
      if (c == 13) begin
        chk("midrst_outputs", int'({bus.s_we, bus.ram_we, bus.done, bus.s_addr}), 0);
        rst = 1'b0;
      end
      if (c > 13 && (bus.s_we || bus.ram_we)) chk("midrst_no_writes", c, 0);
    end
    load();
    idle(1);
    run(1'b0, d);
    check_table(0);
    check_run("rerun", d);

    // Handshake: start held through DONE, then dropped and raised again
    idle(2);
    load();
    idle(1);
    run(1'b1, d);
    check_run("hold", d);
    y = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.done || bus.s_we || bus.ram_we || !bus.msg_valid) y++;
    end
    chk("hold_stays_done", y, 0);
    bus.start = 1'b0;
    idle(1);
    chk("drop_to_idle", int'(bus.done), 0);
    load();
    run(1'b0, d);
    check_table(0);
    check_run("restart", d);

    // Randomized S permutations and plaintexts
    for (int r = 0; r < 4; r++) begin
      idle(2);
      set_identity();
      for (int x = 255; x > 0; x--) begin
        y = int'($urandom_range(x, 0));
        tmp = init_s[x];
        init_s[x] = init_s[y];
        init_s[y] = tmp;
      end
      model(1'b1);
      for (int k = 0; k < MSG_LEN; k++) begin
        if ($urandom_range(24, 0) == 0) p = bad_chars[$urandom_range(5, 0)];
        else if ($urandom_range(5, 0) == 0) p = 8'h20;
        else p = 8'h61 + 8'($urandom_range(25, 0));
        if (k == MSG_LEN - 1 && r == 0) p = 8'h7a;
        rom[k] = p ^ ks[k];
      end
      model(1'b0);
      load();
      run(1'b0, d);
      check_run($sformatf("rand%0d", r), d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc4_decrypt_message.md
# rc4_decrypt_message

RC4 keystream-generation and decryption stage (PRGA). It runs after the key-schedule shuffle has finished permuting S-memory. It walks the shuffled S array, swaps entries as it goes, and XORs each keystream byte with one byte of the encrypted-message ROM. Each plaintext byte is written to the decrypted-message RAM. It also reports whether every plaintext byte is a lowercase letter or a space, which is the key-search pass/fail criterion.

## Interface
- MSG_LEN, 32, number of message bytes to decrypt.
- MSG_AW, 5, address width of the message ROM/RAM; must satisfy 2^MSG_AW >= MSG_LEN.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level request to begin; sampled only in IDLE.
- s_addr  out  8  S-memory address.
- s_rdata  in  8  S-memory read data, valid the cycle after s_addr is presented with s_we=0.
- s_wdata  out  8  S-memory write data.
- s_we  out  1  S-memory write enable.
- rom_addr  out  MSG_AW  encrypted-message ROM address; same 1-cycle read latency.
- rom_rdata  in  8  encrypted byte.
- ram_addr  out  MSG_AW  decrypted-message RAM address.
- ram_wdata  out  8  plaintext byte.
- ram_we  out  1  RAM write enable.
- done  out  1  high while in DONE.
- msg_valid  out  1  every byte written was in 0x61–0x7A or 0x20; meaningful only while done=1.

## Operation
- Registers: i[7:0], j[7:0], k[MSG_AW-1:0], si, sj, f (8-bit each), msg_valid.
- All index arithmetic (i+1, j+si, si+sj) is modulo 256, with natural 8-bit wrap.
- States and actions, in per-byte order:
  - IDLE: if start, go to RD_I. On the transition, load i=1, j=0, k=0, msg_valid=1.
  - RD_I: s_addr=i.
  - LD_I: si<=s_rdata; j<=j+s_rdata.
  - RD_J: s_addr=j (the updated j).
  - LD_J: sj<=s_rdata.
  - WR_I: s_addr=i, s_wdata=sj, s_we=1.
  - WR_J: s_addr=j, s_wdata=si, s_we=1.
  - RD_F: s_addr=si+sj, rom_addr=k.
  - LD_F: f<=s_rdata; latch rom_rdata.
  - WR_OUT: ram_addr=k, ram_wdata=f^enc, ram_we=1.
    - If the byte is not 0x61–0x7A and not 0x20: clear msg_valid and go to DONE. The invalid byte is still written.
    - Else if k==MSG_LEN-1: go to DONE.
    - Else: i<=i+1, k<=k+1, go to RD_I.
  - DONE: done=1. Return to IDLE when start==0; stay in DONE while start==1.
- Case i==j: WR_J overwrites WR_I at the same address with si. The net effect is S unchanged, which is the correct swap result.
- Outputs are Moore decodes of state plus registers.
  - Outside the states listed above: s_we=0, ram_we=0, and all addresses and write data are 0.
  - rom_addr is 0 outside RD_F.
- start while not in IDLE is ignored.

## Timing
- Reset: state=IDLE; i, j, k, si, sj, f and msg_valid all 0.
  - Outputs from the cycle after rst is sampled: done=0, msg_valid=0, s_we=0, ram_we=0, all addresses and data 0.
- Reset asserted mid-operation aborts immediately; no further memory writes occur.
- Latency: 9 cycles per byte. With start sampled at edge 0, the cycles are:
  - RD_I = cycle 1
  - WR_I = cycle 5
  - WR_J = cycle 6
  - WR_OUT = cycle 9
- Full message: first DONE cycle is 9*MSG_LEN+1 (289 for MSG_LEN=32).
- Early abort at byte n: DONE in cycle 9*(n+1)+1.
- Handshake: start may be held high through completion. A new run requires start low for at least one cycle in DONE, then high in IDLE.
- msg_valid updates only in WR_OUT and at start. It is stable throughout DONE.

## Test plan
- Identity S (S[x]=x), enc[0]=0x63:
  - Cycle 5: s_we, addr 0x01, data 0x01.
  - Cycle 6: s_we, addr 0x01, data 0x01.
  - Cycle 9: ram_we, addr 0, data 0x61.
- Continue the first scenario with enc[1]=0x64:
  - Cycle 14: s_we, addr 0x02, data 0x03.
  - Cycle 15: s_we, addr 0x03, data 0x02.
  - Cycle 18: ram_we, addr 1, data 0x61 (f=0x05).
- Full valid message: precompute enc from a golden RC4 model over identity S so that the plaintext is all 'a'. Required: 32 RAM writes matching the model, done first high at cycle 289, msg_valid=1, final S matches the model.
- Early abort: identity S, enc[0]=0x63, enc[1]=0x00. Required:
  - Cycle 18: RAM write addr 1, data 0x05.
  - Cycle 19: done=1, msg_valid=0.
  - No write to RAM address 2.
- Reset mid-run: assert rst in cycle 12. Required:
  - From cycle 13: s_we=0, ram_we=0, done=0.
  - A subsequent start reproduces the first scenario's exact write sequence.
- Handshake: hold start high through DONE and confirm done stays 1 with no new writes. Drop start for 1 cycle, then raise it: the FSM re-enters RD_I and the next run matches the first run.
